// File: rtl/spi_ram_burst.sv
// SPI-style slave giving burst access to an on-chip word memory.
// Frames are cmd[1:0] + payload; set write/read pointers, write words, or stream a word out on MISO.
module spi_ram_burst #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n,
    input  logic MOSI,
    output logic MISO
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {IDLE, RX, EXEC, TX} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [FRAME_W-1:0]  frame;
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [DATA_W-1:0]   tx_reg;
    logic [DATA_W-1:0]   mem [MEM_DEPTH];
    logic                shift_en, exec_en, tx_en;
    logic [1:0]          cmd;
    logic [DATA_W-1:0]   payload;

    assign cmd     = frame[FRAME_W-1 -: 2];
    assign payload = frame[DATA_W-1:0];

    // Pointers must stay inside the memory even when MEM_DEPTH is not a power of two.
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = 32'(a) % 32'(MEM_DEPTH);
        return t[ADDR_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (32'(a) == 32'(MEM_DEPTH - 1))
            return '0;
        return a + ADDR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_en    = 1'b0;
        exec_en     = 1'b0;
        tx_en       = 1'b0;
        if (ss_n) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt   = RX;
                    bit_cnt_nxt = '0;
                end
                RX: begin
                    shift_en = 1'b1;
                    if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                        state_nxt   = EXEC;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
                EXEC: begin
                    exec_en     = 1'b1;
                    bit_cnt_nxt = '0;
                    state_nxt   = (cmd == CMD_RD_DATA) ? TX : RX;
                end
                TX: begin
                    tx_en = 1'b1;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        state_nxt   = RX;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Command execution; tx_reg shifts left so its MSB is always the next bit to send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            tx_reg <= '0;
            MISO   <= 1'b0;
        end else begin
            MISO <= tx_en ? tx_reg[DATA_W-1] : 1'b0;
            if (tx_en)
                tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
            if (exec_en) begin
                unique case (cmd)
                    CMD_WR_ADDR: wr_ptr <= wrap_addr(payload[ADDR_W-1:0]);
                    CMD_WR_DATA: if (AUTO_INC != 0) wr_ptr <= next_addr(wr_ptr);
                    CMD_RD_ADDR: rd_ptr <= wrap_addr(payload[ADDR_W-1:0]);
                    CMD_RD_DATA: begin
                        tx_reg <= mem[rd_ptr];
                        if (AUTO_INC != 0) rd_ptr <= next_addr(rd_ptr);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Frame shifter and memory array carry data only and are never reset.
    always_ff @(posedge clk) begin
        if (shift_en)
            frame <= {frame[FRAME_W-2:0], MOSI};
        if (exec_en && cmd == CMD_WR_DATA)
            mem[wr_ptr] <= payload;
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: default, AUTO_INC=0 and MEM_DEPTH=200 instances.
module tb_spi_ram_burst;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ss_n_v = 3'b111;
    logic [2:0] mosi_v = 3'b000;
    logic       miso0, miso1, miso2;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] b;

    always #5 clk = ~clk;

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n_v[0]), .MOSI(mosi_v[0]), .MISO(miso0));
    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n_v[1]), .MOSI(mosi_v[1]), .MISO(miso1));
    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n_v[2]), .MOSI(mosi_v[2]), .MISO(miso2));

    function automatic logic miso_of(input int k);
        return (k == 0) ? miso0 : (k == 1) ? miso1 : miso2;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic open_win(input int k);
        ss_n_v[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic close_win(input int k);
        ss_n_v[k] = 1'b1;
        mosi_v[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input int k, input logic [1:0] cmd, input logic [7:0] pl);
        logic [9:0] f;
        f = {cmd, pl};
        for (int i = 9; i >= 0; i--) begin
            mosi_v[k] = f[i];
            @(negedge clk);
        end
        mosi_v[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_byte(input int k, output logic [7:0] v);
        v = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v = {v[6:0], miso_of(k)};
        end
    endtask

    task automatic rd_check(input int k, input string tag, input logic [7:0] exp);
        logic [7:0] v;
        send_frame(k, 2'b11, 8'h00);
        read_byte(k, v);
        check(tag, v, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_miso", {7'b0, miso0}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        open_win(0);
        send_frame(0, 2'b00, 8'h10);
        send_frame(0, 2'b01, 8'hA5);
        send_frame(0, 2'b01, 8'h5A);
        send_frame(0, 2'b10, 8'h10);
        rd_check(0, "burst_rd0", 8'hA5);
        rd_check(0, "burst_rd1", 8'h5A);
        @(negedge clk);
        check("miso_after_tx", {7'b0, miso0}, 8'h00);
        close_win(0);
        check("miso_idle", {7'b0, miso0}, 8'h00);

        open_win(0);
        send_frame(0, 2'b00, 8'hFF);
        send_frame(0, 2'b01, 8'h11);
        send_frame(0, 2'b01, 8'h22);
        close_win(0);
        open_win(0);
        send_frame(0, 2'b10, 8'hFF);
        rd_check(0, "wrap_ff", 8'h11);
        rd_check(0, "wrap_00", 8'h22);
        close_win(0);

        open_win(0);
        send_frame(0, 2'b00, 8'h20);
        send_frame(0, 2'b01, 8'h33);
        close_win(0);
        open_win(0);
        begin
            logic [9:0] f;
            f = {2'b01, 8'h77};
            for (int i = 9; i >= 5; i--) begin
                mosi_v[0] = f[i];
                @(negedge clk);
            end
        end
        close_win(0);
        open_win(0);
        send_frame(0, 2'b01, 8'h44);
        send_frame(0, 2'b10, 8'h21);
        rd_check(0, "abort_next", 8'h44);
        send_frame(0, 2'b10, 8'h20);
        rd_check(0, "abort_prev", 8'h33);
        close_win(0);

        open_win(0);
        send_frame(0, 2'b10, 8'h10);
        send_frame(0, 2'b11, 8'h00);
        @(negedge clk);
        check("tx_bit7", {7'b0, miso0}, 8'h01);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_tx", {7'b0, miso0}, 8'h00);
        ss_n_v[0] = 1'b1;
        mosi_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        open_win(0);
        rd_check(0, "rst_rd_mem0", 8'h22);
        send_frame(0, 2'b01, 8'h66);
        send_frame(0, 2'b10, 8'h00);
        rd_check(0, "rst_wr_ptr0", 8'h66);
        close_win(0);

        open_win(1);
        send_frame(1, 2'b00, 8'h03);
        send_frame(1, 2'b01, 8'h9C);
        send_frame(1, 2'b01, 8'h3C);
        send_frame(1, 2'b10, 8'h03);
        rd_check(1, "noinc_rd0", 8'h3C);
        rd_check(1, "noinc_rd1", 8'h3C);
        close_win(1);

        open_win(2);
        send_frame(2, 2'b00, 8'hC7);
        send_frame(2, 2'b01, 8'h01);
        send_frame(2, 2'b01, 8'h02);
        send_frame(2, 2'b10, 8'hC7);
        rd_check(2, "d200_rd199", 8'h01);
        rd_check(2, "d200_rdwrap", 8'h02);
        send_frame(2, 2'b00, 8'hC8);
        send_frame(2, 2'b01, 8'h55);
        send_frame(2, 2'b10, 8'h00);
        rd_check(2, "d200_addr_mod", 8'h55);
        close_win(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_burst.md
SPI_RAM_BURST -- requirements
Module: spi_ram_burst

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the memory word width and the frame payload width.
REQ-002 Parameter ADDR_W, default 8, SHALL set the pointer width; legal only with ADDR_W <= DATA_W.
REQ-003 Parameter MEM_DEPTH, default 256, SHALL set the word count; legal only with MEM_DEPTH <= 2**ADDR_W.
REQ-004 Parameter AUTO_INC, default 1, SHALL enable (1) or disable (0) pointer post-increment after each data access.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all sampling and updates occur on its rising edge.
REQ-006 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-007 Port ss_n, input, 1 bit, SHALL be the active-low slave select.
REQ-008 Port MOSI, input, 1 bit, SHALL be the serial command/data input, sampled MSB first.
REQ-009 Port MISO, output, 1 bit, SHALL be the registered serial read-data output, MSB first.

Function
REQ-010 A frame SHALL be FRAME_W = 2 + DATA_W bits: cmd[1:0], then payload[DATA_W-1:0].
REQ-011 States SHALL be IDLE, RX, EXEC and TX.
REQ-012 IDLE: ss_n sampled low -> RX with bit count 0; no bit is sampled on this edge.
REQ-013 RX: each edge shifts MOSI into the frame register; the edge that captures bit FRAME_W -> EXEC.
REQ-014 EXEC, cmd 00 (WR_ADDR): wr_ptr <= payload[ADDR_W-1:0] mod MEM_DEPTH; -> RX.
REQ-015 EXEC, cmd 01 (WR_DATA): mem[wr_ptr] <= payload; if AUTO_INC, wr_ptr <= (wr_ptr+1) mod MEM_DEPTH; -> RX.
REQ-016 EXEC, cmd 10 (RD_ADDR): rd_ptr <= payload[ADDR_W-1:0] mod MEM_DEPTH; -> RX.
REQ-017 EXEC, cmd 11 (RD_DATA): tx_reg <= mem[rd_ptr]; if AUTO_INC, rd_ptr <= (rd_ptr+1) mod MEM_DEPTH; payload ignored; -> TX.
REQ-018 TX: each of DATA_W edges SHALL drive MISO <= tx_reg bit (MSB first); MOSI is ignored; after the DATA_W-th edge -> RX.
REQ-019 MISO SHALL be 0 on every edge not in TX, including the first edge after TX ends.
REQ-020 Any number of frames SHALL be accepted in one ss_n-low window (burst), with no dead cycle between frames other than EXEC and TX.
REQ-021 ss_n sampled high in any state SHALL force IDLE on that edge; a partial frame or partial TX is discarded with no memory or pointer change.
REQ-022 Pointers and memory SHALL persist across ss_n windows.
REQ-023 Pointer wrap: an increment from MEM_DEPTH-1 SHALL yield 0.
REQ-024 Write latency: the memory SHALL be updated on edge FRAME_W+1 after the RX entry edge, and a read frame starting in the next window position SHALL return the new value.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, MISO=0, wr_ptr=0, rd_ptr=0, bit count 0 and tx_reg=0, in any state including mid-TX.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Operation SHALL resume on the first rising edge after rst_n is released, when ss_n is low.

Verification (DATA_W=8, ADDR_W=8, MEM_DEPTH=256 unless noted)
REQ-028 Reset: assert rst_n=0 mid-TX -> MISO=0 within the same cycle; after release, RD_DATA returns mem[0].
REQ-029 Burst: in one window send WR_ADDR 0x10, WR_DATA 0xA5, WR_DATA 0x5A, RD_ADDR 0x10, RD_DATA, RD_DATA -> MISO bytes 0xA5 then 0x5A.
REQ-030 Wrap: send WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22.
REQ-031 Abort: raise ss_n after 5 bits of WR_DATA 0x77 -> no write and wr_ptr unchanged; the next full frame decodes correctly.
REQ-032 AUTO_INC=0: RD_ADDR 0x03, then RD_DATA twice -> the same byte twice; wr_ptr is unchanged after two WR_DATA frames.
REQ-033 MEM_DEPTH=200: WR_ADDR 0xC7, WR_DATA 0x01, WR_DATA 0x02 -> mem[199]=0x01, mem[0]=0x02.
